// File: rtl/psi_t_framer.sv
// psi_t sample FIFO (first-word-fall-through) re-emitted as a ready/valid stream
// with m_tlast every FRAME_LEN transfers. Optional NaN/Inf scrub: PSI_T_FRAMER_NANCHK_EN.
module psi_t_framer #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              psi_t,
  input  logic                     psi_t_vld,
  output logic [63:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              frames,
  output logic                     overflow,
  output logic                     nan_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   pos;
  logic          full;
  logic          push;
  logic          drop;
  logic          pop;
  logic [63:0]   wdata;

  // Fullness is judged on the registered fill, so a same-cycle pop never makes room.
  assign full     = (fill == (AW+1)'(DEPTH));
  assign push     = psi_t_vld && !full;
  assign drop     = psi_t_vld && full;
  assign m_tvalid = (fill != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tlast  = m_tvalid && (pos == 16'(FRAME_LEN - 1));

`ifdef PSI_T_FRAMER_NANCHK_EN
  logic non_finite;

  assign non_finite = (psi_t[62:52] == 11'h7FF);
  assign wdata      = non_finite ? '0 : psi_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_err <= 1'b0;
    end else if (push && non_finite) begin
      nan_err <= 1'b1;
    end else if (clr_err) begin
      nan_err <= 1'b0;
    end
  end
`else
  assign wdata   = psi_t;
  assign nan_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      pos      <= '0;
      frames   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (m_tlast) begin
          pos    <= '0;
          frames <= frames + 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end
      if (push && !pop) begin
        fill <= fill + 1'b1;
      end else if (!push && pop) begin
        fill <= fill - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psi_t_framer.sv
// Bench for psi_t_framer: queue-based reference model checked every cycle,
// plus directed phases with hand-computed expectations.
module tb_psi_t_framer;

  localparam int DEPTH = 16;
  localparam int FL    = 4;

  logic        clk;
  logic        rst;
  logic [63:0] psi_t;
  logic        psi_t_vld;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [4:0]  fill;
  logic [15:0] frames;
  logic        overflow;
  logic        nan_err;
  logic        clr_err;

  psi_t_framer #(.DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .psi_t(psi_t), .psi_t_vld(psi_t_vld),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .fill(fill), .frames(frames), .overflow(overflow), .nan_err(nan_err),
    .clr_err(clr_err)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain queue of stored words plus a running transfer count.
  logic [63:0] mq[$];
  int unsigned n_xfer;
  logic        m_ov;
  logic        m_nan;
  logic [63:0] got[$];
  logic        gotlast[$];
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    logic        ev_ov;
    logic        ev_nan;
    logic [63:0] w;
    logic        exp_valid;
    if (rst) begin
      mq.delete();
      n_xfer     = 0;
      m_ov       = 1'b0;
      m_nan      = 1'b0;
      prev_stall = 1'b0;
    end
    exp_valid = (mq.size() != 0);
    check("m_tvalid", {63'd0, m_tvalid}, {63'd0, exp_valid});
    check("m_tdata", m_tdata, exp_valid ? mq[0] : 64'h0);
    check("m_tlast", {63'd0, m_tlast}, {63'd0, exp_valid && (n_xfer % FL == FL - 1)});
    check("fill", {59'd0, fill}, 64'(mq.size()));
    check("frames", {48'd0, frames}, {48'd0, 16'(n_xfer / FL)});
    check("overflow", {63'd0, overflow}, {63'd0, m_ov});
    check("nan_err", {63'd0, nan_err}, {63'd0, m_nan});
    if (prev_stall && !rst) begin
      check("stall_valid", {63'd0, m_tvalid}, 64'd1);
      check("stall_data", m_tdata, prev_data);
      check("stall_last", {63'd0, m_tlast}, {63'd0, prev_last});
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (!rst) begin
      ev_ov  = 1'b0;
      ev_nan = 1'b0;
      if (psi_t_vld && mq.size() == DEPTH) begin
        ev_ov = 1'b1;
      end
      if (m_tvalid && m_tready) begin
        got.push_back(m_tdata);
        gotlast.push_back(m_tlast);
      end
      if (exp_valid && m_tready) begin
        void'(mq.pop_front());
        n_xfer++;
      end
      if (psi_t_vld && !ev_ov) begin
        w = psi_t;
`ifdef PSI_T_FRAMER_NANCHK_EN
        if (psi_t[62:52] == 11'h7FF) begin
          w      = 64'h0;
          ev_nan = 1'b1;
        end
`endif
        mq.push_back(w);
      end
      m_ov  = ev_ov  ? 1'b1 : (clr_err ? 1'b0 : m_ov);
      m_nan = ev_nan ? 1'b1 : (clr_err ? 1'b0 : m_nan);
    end
  end

  task automatic step(input int unsigned k = 1);
    for (int unsigned i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    psi_t_vld = 1'b0;
    m_tready = 1'b0;
    clr_err = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    got.delete();
    gotlast.delete();
  endtask

  initial begin
    int unsigned errs;
    int unsigned lasts;
    rst = 1'b1;
    psi_t = '0;
    psi_t_vld = 1'b0;
    m_tready = 1'b0;
    clr_err = 1'b0;
    do_reset();
    check("rst_valid", {63'd0, m_tvalid}, 64'd0);
    check("rst_fill", {59'd0, fill}, 64'd0);
    check("rst_data", m_tdata, 64'h0);

    // Three samples in order, first-push latency.
    m_tready = 1'b1;
    psi_t_vld = 1'b1;
    psi_t = 64'h3FF0000000000000;
    check("lat_before", {63'd0, m_tvalid}, 64'd0);
    step();
    check("lat_after", {63'd0, m_tvalid}, 64'd1);
    check("lat_data", m_tdata, 64'h3FF0000000000000);
    psi_t = 64'h4000000000000000;
    step();
    psi_t = 64'h4008000000000000;
    step();
    psi_t_vld = 1'b0;
    step(3);
    check("three_fill", {59'd0, fill}, 64'd0);
    check("three_cnt", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("three_0", got[0], 64'h3FF0000000000000);
      check("three_1", got[1], 64'h4000000000000000);
      check("three_2", got[2], 64'h4008000000000000);
    end

    // Framing: 8 samples, FRAME_LEN=4.
    do_reset();
    m_tready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      psi_t_vld = 1'b1;
      psi_t = 64'h40 + 64'(i);
      step();
    end
    psi_t_vld = 1'b0;
    step(4);
    check("frames_two", {48'd0, frames}, 64'd2);
    lasts = 0;
    foreach (gotlast[i]) lasts += gotlast[i];
    check("last_count", 64'(lasts), 64'd2);
    if (gotlast.size() == 8) begin
      check("last_4", {63'd0, gotlast[3]}, 64'd1);
      check("last_8", {63'd0, gotlast[7]}, 64'd1);
    end

    // Overflow with stalled consumer, drain, clear.
    do_reset();
    for (int unsigned i = 0; i < 18; i++) begin
      psi_t_vld = 1'b1;
      psi_t = 64'h100 + 64'(i);
      step();
    end
    psi_t_vld = 1'b0;
    check("full_fill", {59'd0, fill}, 64'd16);
    check("full_ovf", {63'd0, overflow}, 64'd1);
    m_tready = 1'b1;
    step(20);
    check("drain_cnt", 64'(got.size()), 64'd16);
    errs = 0;
    foreach (got[i]) if (got[i] !== 64'h100 + 64'(i)) errs++;
    check("drain_vals", 64'(errs), 64'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_ovf", {63'd0, overflow}, 64'd0);

    // Full FIFO, push and pop in the same cycle.
    do_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      psi_t_vld = 1'b1;
      psi_t = 64'h200 + 64'(i);
      step();
    end
    m_tready = 1'b1;
    psi_t = 64'hDEAD;
    step();
    psi_t_vld = 1'b0;
    m_tready = 1'b0;
    check("fullpop_fill", {59'd0, fill}, 64'd15);
    check("fullpop_ovf", {63'd0, overflow}, 64'd1);
    check("fullpop_head", m_tdata, 64'h201);

    // Randomized traffic against the model.
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      psi_t_vld = ($urandom_range(9) < 3);
      psi_t = {$urandom, $urandom};
      if ($urandom_range(15) == 0) psi_t[62:52] = 11'h7FF;
      m_tready = $urandom_range(1);
      clr_err = ($urandom_range(49) == 0);
      step();
    end
    psi_t_vld = 1'b0;
    clr_err = 1'b0;
    m_tready = 1'b1;
    step(20);
    check("rand_empty", {63'd0, m_tvalid}, 64'd0);

    // Non-finite sample handling.
    do_reset();
    psi_t_vld = 1'b1;
    psi_t = 64'h7FF8000000000000;
    step();
    psi_t_vld = 1'b0;
`ifdef PSI_T_FRAMER_NANCHK_EN
    check("nan_data", m_tdata, 64'h0);
    check("nan_flag", {63'd0, nan_err}, 64'd1);
`else
    check("nan_data", m_tdata, 64'h7FF8000000000000);
    check("nan_flag", {63'd0, nan_err}, 64'd0);
`endif

    // Asynchronous reset mid-stream.
    do_reset();
    m_tready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      psi_t_vld = 1'b1;
      psi_t = 64'h300 + 64'(i);
      step();
    end
    psi_t_vld = 1'b0;
    m_tready = 1'b1;
    check("pre_rst_fill", {59'd0, fill}, 64'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, m_tvalid}, 64'd0);
    check("arst_data", m_tdata, 64'h0);
    check("arst_fill", {59'd0, fill}, 64'd0);
    check("arst_last", {63'd0, m_tlast}, 64'd0);
    check("arst_frames", {48'd0, frames}, 64'd0);
    step(2);
    rst = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psi_t_framer.md
# psi_t_framer

Downstream stage of the ψ-term datapath: buffers the double-precision `psi_t` samples, which arrive with a valid strobe and no back-pressure, in a small FIFO. It re-emits them as a ready/valid stream with a `m_tlast` frame marker every FRAME_LEN samples for the result writer. It absorbs consumer stalls and flags any sample lost to overflow.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in 64-bit words; power of two, ≥ 2.
- FRAME_LEN, 64: samples per output frame; 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- psi_t  in  64  IEEE-754 double sample from the ψ_t stage.
- psi_t_vld  in  1  single-cycle qualifier for `psi_t`; may be high every cycle.
- m_tdata  out  64  head-of-FIFO sample; 64'h0 whenever `m_tvalid`=0.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  consumer accepts `m_tdata` this cycle.
- m_tlast  out  1  current `m_tdata` is the last sample of a frame.
- fill  out  log2(DEPTH)+1  number of stored words, 0..DEPTH.
- frames  out  16  completed frames since reset; wraps 65535→0.
- overflow  out  1  sticky: a valid sample arrived while full.
- nan_err  out  1  sticky non-finite-input flag (see Configuration).
- clr_err  in  1  synchronous clear of `overflow` and `nan_err`.

## Operation
- Storage: DEPTH×64 register array; write pointer and read pointer of log2(DEPTH) bits each, both wrapping DEPTH-1→0. `fill` is a separate counter.
- Write: on `psi_t_vld`=1 and `fill`<DEPTH, store `psi_t` at the write pointer and advance the write pointer.
- Write while full: if `psi_t_vld`=1 and `fill`=DEPTH, the sample is dropped and `overflow` is set. Fullness uses the registered `fill` at the start of the cycle, so a same-cycle pop does not make room.
- Read: the FIFO is first-word-fall-through. `m_tdata` is the word at the read pointer. A transfer occurs when `m_tvalid`=1 and `m_tready`=1; it advances the read pointer.
- Simultaneous push and pop with 0<`fill`<DEPTH: both pointers advance and `fill` is unchanged.
- Push into an empty FIFO while `m_tready`=1: there is no same-cycle bypass; the word appears the next cycle.
- Frame position: a 16-bit counter `pos` counts output transfers only, so dropped samples never shift framing.
  - `m_tlast` = `m_tvalid` and (`pos` = FRAME_LEN-1).
  - A transfer with `m_tlast`=1 sets `pos` to 0 and increments `frames`; any other transfer increments `pos`.
  - With FRAME_LEN=1, every valid word carries `m_tlast`.
- Stall: while `m_tready`=0, `m_tdata`, `m_tvalid` and `m_tlast` hold stable.
- Sticky flags: `clr_err`=1 clears both flags at the next edge. If a new error event occurs in the same cycle, the set wins.

## Timing
- Reset values: pointers 0, `fill` 0, `pos` 0, `frames` 0, `m_tvalid` 0, `m_tlast` 0, `m_tdata` 64'h0, `overflow` 0, `nan_err` 0. Array contents are not reset.
- Reset mid-operation clears all stored samples and frame position immediately, because reset is asynchronous. Release is synchronous to `clk`.
- Latency from `psi_t_vld` at edge N into an empty FIFO: `m_tvalid`=1 after edge N, visible in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- `fill` and `m_tvalid` update at the same edge as the pointer changes.

## Configuration
- `PSI_T_FRAMER_NANCHK_EN` defined:
  - Each accepted sample with exponent bits [62:52] = 11'h7FF (NaN or ±Inf) is stored as 64'h0 (+0.0).
  - `nan_err` is set at the same edge.
  - A dropped (overflowing) non-finite sample sets only `overflow`.
- Not defined: samples are stored bit-exact and `nan_err` is tied to 0.

## Test plan
- Reset, then push 3 samples (3FF0000000000000, 4000000000000000, 4008000000000000) with `m_tready`=1 → same values out in order; `m_tvalid` rises one cycle after the first push; `fill` returns to 0.
- FRAME_LEN=4: stream 8 samples with `m_tready`=1 → `m_tlast` on output transfers 4 and 8; `frames`=2.
- DEPTH=16, `m_tready`=0: push 18 samples → `fill`=16, `overflow`=1; drain → exactly the first 16 values; pulse `clr_err` → `overflow`=0.
- Full FIFO with `m_tready`=1 and `psi_t_vld`=1 in the same cycle → incoming sample dropped, `overflow`=1, `fill`=15 next cycle.
- Random `m_tready` at 50% with a continuous `psi_t_vld` at 30% duty → no loss, order preserved, `m_tdata` stable during stalls.
- With `PSI_T_FRAMER_NANCHK_EN`: push 7FF8000000000000 → output 0000000000000000, `nan_err`=1. Assert `rst` mid-stream → all outputs at reset values within the same cycle.
